wave_analyzer: RTL and testbench

//   Receive-side measurement block for the 16-bit signed waveform stream.

---
 rtl/wave_analyzer_if.sv | 41 ++++
 rtl/wave_analyzer.sv | 180 ++++++++++++++++++
 tb/tb_wave_analyzer.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/wave_analyzer_if.sv
// wave_analyzer_if
//   Bundles the sample stream feeding the wave analyzer and the measurement
//   results it reports.
//   Signals:
//     sample_in     signed 16-bit waveform sample
//     sample_valid  sample_in is valid this cycle
//     hysteresis    unsigned 15-bit crossing threshold magnitude
//     result_valid  one-cycle pulse, result fields just updated
//     period        valid samples in the last complete cycle
//     high_time     valid samples with level high in the last cycle
//     peak_max      signed maximum sample of the last cycle
//     peak_min      signed minimum sample of the last cycle
//     locked        at least one result since reset or timeout
//     timeout       one-cycle pulse on loss of signal
//   Modports:
//     master  the sample source, which also consumes the results
//     slave   the analyzer
interface wave_analyzer_if #(
  parameter int PERIOD_W = 24
);
  logic signed [15:0]   sample_in;
  logic                 sample_valid;
  logic [14:0]          hysteresis;
  logic                 result_valid;
  logic [PERIOD_W-1:0]  period;
  logic [PERIOD_W-1:0]  high_time;
  logic signed [15:0]   peak_max;
  logic signed [15:0]   peak_min;
  logic                 locked;
  logic                 timeout;

  modport master (
    output sample_in, sample_valid, hysteresis,
    input  result_valid, period, high_time, peak_max, peak_min, locked, timeout
  );

  modport slave (
    input  sample_in, sample_valid, hysteresis,
    output result_valid, period, high_time, peak_max, peak_min, locked, timeout
  );
endinterface

// File: rtl/wave_analyzer.sv
// wave_analyzer
//   Receive-side measurement block for a signed 16-bit waveform stream.
//   Tracks a hysteresis level, detects rising crossings and, for every
//   complete cycle between two rises, reports period, high time and the
//   signed peak maximum and minimum. Loss of signal raises a timeout pulse.
//   Ports:
//     clk      system clock, all logic on posedge
//     rst      asynchronous active-high reset
//     wave_if  slave side of wave_analyzer_if (samples in, results out)
//   Parameters:
//     PERIOD_W    width of the period/high-time counters and outputs
//     MAX_PERIOD  valid samples without a rise before timeout
//                 (must fit in PERIOD_W bits)
module wave_analyzer #(
  parameter int PERIOD_W   = 24,
  parameter int MAX_PERIOD = 2**24 - 1
) (
  input logic           clk,
  input logic           rst,
  wave_analyzer_if.slave wave_if
);

  typedef enum logic {
    ACQ  = 1'b0,
    MEAS = 1'b1
  } state_e;

  localparam logic [PERIOD_W-1:0] CNT_ONE   = {{(PERIOD_W-1){1'b0}}, 1'b1};
  localparam logic [PERIOD_W-1:0] CNT_LIMIT = PERIOD_W'(MAX_PERIOD);
  localparam logic signed [15:0]  RUN_MAX_INIT = 16'sh8000;
  localparam logic signed [15:0]  RUN_MIN_INIT = 16'sh7fff;

  state_e               state_q, state_d;
  logic                 level_q, level_d;
  logic [PERIOD_W-1:0]  cnt_q, cnt_d;
  logic [PERIOD_W-1:0]  hcnt_q, hcnt_d;
  logic signed [15:0]   runMax_q, runMax_d;
  logic signed [15:0]   runMin_q, runMin_d;
  logic                 resultValid_q, resultValid_d;
  logic [PERIOD_W-1:0]  period_q, period_d;
  logic [PERIOD_W-1:0]  highTime_q, highTime_d;
  logic signed [15:0]   peakMax_q, peakMax_d;
  logic signed [15:0]   peakMin_q, peakMin_d;
  logic                 locked_q, locked_d;
  logic                 timeout_q, timeout_d;

  logic signed [16:0]   sampleExt;
  logic signed [16:0]   hPos;
  logic signed [16:0]   hNeg;
  logic                 levelNew;
  logic                 rise;
  logic                 timeoutHit;

  // Level tracker with 17-bit signed compares so that -H never overflows and
  // full-scale samples compare correctly. A sample inside [-H, +H] holds the
  // previous level, which with H=0 means a zero sample holds.
  always_comb begin
    sampleExt = {wave_if.sample_in[15], wave_if.sample_in};
    hPos      = {2'b00, wave_if.hysteresis};
    hNeg      = -hPos;
    levelNew  = level_q;
    if (sampleExt > hPos) begin
      levelNew = 1'b1;
    end else if (sampleExt < hNeg) begin
      levelNew = 1'b0;
    end
    rise       = wave_if.sample_valid && !level_q && levelNew;
    // The limit check happens before any increment, so cnt never wraps; a
    // rise on the same sample takes priority over the timeout.
    timeoutHit = wave_if.sample_valid && !rise && (cnt_q == CNT_LIMIT);
  end

  // State register together with the counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ACQ;
      level_q       <= 1'b0;
      cnt_q         <= '0;
      hcnt_q        <= '0;
      runMax_q      <= RUN_MAX_INIT;
      runMin_q      <= RUN_MIN_INIT;
      resultValid_q <= 1'b0;
      period_q      <= '0;
      highTime_q    <= '0;
      peakMax_q     <= '0;
      peakMin_q     <= '0;
      locked_q      <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      level_q       <= level_d;
      cnt_q         <= cnt_d;
      hcnt_q        <= hcnt_d;
      runMax_q      <= runMax_d;
      runMin_q      <= runMin_d;
      resultValid_q <= resultValid_d;
      period_q      <= period_d;
      highTime_q    <= highTime_d;
      peakMax_q     <= peakMax_d;
      peakMin_q     <= peakMin_d;
      locked_q      <= locked_d;
      timeout_q     <= timeout_d;
    end
  end

  // Next-state logic: any rise starts (or restarts) a measurement, a timeout
  // drops back to acquisition.
  always_comb begin
    state_d = state_q;
    if (rise) begin
      state_d = MEAS;
    end else if (timeoutHit) begin
      state_d = ACQ;
    end
  end

  // Output and datapath logic. Invalid cycles leave everything untouched and
  // the pulse outputs fall back to zero. In ACQ the counter still advances so
  // that a dead input also produces a timeout.
  always_comb begin
    level_d       = level_q;
    cnt_d         = cnt_q;
    hcnt_d        = hcnt_q;
    runMax_d      = runMax_q;
    runMin_d      = runMin_q;
    resultValid_d = 1'b0;
    period_d      = period_q;
    highTime_d    = highTime_q;
    peakMax_d     = peakMax_q;
    peakMin_d     = peakMin_q;
    locked_d      = locked_q;
    timeout_d     = 1'b0;
    if (wave_if.sample_valid) begin
      level_d = levelNew;
      if (rise) begin
        if (state_q == MEAS) begin
          period_d      = cnt_q;
          highTime_d    = hcnt_q;
          peakMax_d     = runMax_q;
          peakMin_d     = runMin_q;
          resultValid_d = 1'b1;
          locked_d      = 1'b1;
        end
        cnt_d    = CNT_ONE;
        hcnt_d   = CNT_ONE;
        runMax_d = wave_if.sample_in;
        runMin_d = wave_if.sample_in;
      end else if (timeoutHit) begin
        timeout_d = 1'b1;
        locked_d  = 1'b0;
        cnt_d     = '0;
        hcnt_d    = '0;
        runMax_d  = RUN_MAX_INIT;
        runMin_d  = RUN_MIN_INIT;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
        if (state_q == MEAS) begin
          if (levelNew) begin
            hcnt_d = hcnt_q + CNT_ONE;
          end
          if (wave_if.sample_in > runMax_q) begin
            runMax_d = wave_if.sample_in;
          end
          if (wave_if.sample_in < runMin_q) begin
            runMin_d = wave_if.sample_in;
          end
        end
      end
    end
  end

  assign wave_if.result_valid = resultValid_q;
  assign wave_if.period       = period_q;
  assign wave_if.high_time    = highTime_q;
  assign wave_if.peak_max     = peakMax_q;
  assign wave_if.peak_min     = peakMin_q;
  assign wave_if.locked       = locked_q;
  assign wave_if.timeout      = timeout_q;

endmodule

// File: tb/tb_wave_analyzer.sv
// tb_wave_analyzer
//   Self-checking bench for wave_analyzer. A reference model keeps the
//   samples seen since the last rise in a queue and derives period, high
//   time and peaks from that queue whenever a new rise arrives.
module tb_wave_analyzer;
  localparam int PERIOD_W   = 24;
  localparam int MAX_PERIOD = 64;

  logic clk;
  logic rst;

  wave_analyzer_if #(.PERIOD_W(PERIOD_W)) wif ();

  wave_analyzer #(
    .PERIOD_W  (PERIOD_W),
    .MAX_PERIOD(MAX_PERIOD)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .wave_if(wif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int pulseCount = 0;

  // reference model state
  bit mLevel;
  bit mMeas;
  int mBuf[$];
  int mHighBuf[$];
  int ePeriod, eHigh, eMax, eMin;
  bit eRv, eTo, eLocked;

  // Single comparison point: counts and reports.
  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed %0d, expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  // Model reset: everything back to power-on values.
  task automatic modelReset();
    mLevel = 0; mMeas = 0;
    mBuf.delete(); mHighBuf.delete();
    ePeriod = 0; eHigh = 0; eMax = 0; eMin = 0;
    eRv = 0; eTo = 0; eLocked = 0;
  endtask

  // Model step for one sample, written from the behavioural rules.
  task automatic modelStep(input int s, input bit v, input int h);
    bit newLevel;
    int mx, mn, hi;
    eRv = 0; eTo = 0;
    if (!v) return;
    newLevel = mLevel;
    if (s > h) newLevel = 1;
    else if (s < -h) newLevel = 0;
    if (!mLevel && newLevel) begin
      if (mMeas) begin
        mx = -32768; mn = 32767; hi = 0;
        foreach (mBuf[i]) begin
          if (mBuf[i] > mx) mx = mBuf[i];
          if (mBuf[i] < mn) mn = mBuf[i];
          hi += mHighBuf[i];
        end
        ePeriod = mBuf.size(); eHigh = hi; eMax = mx; eMin = mn;
        eRv = 1; eLocked = 1;
      end
      mBuf.delete(); mHighBuf.delete();
      mBuf.push_back(s); mHighBuf.push_back(1);
      mMeas = 1;
    end else if (mBuf.size() == MAX_PERIOD) begin
      eTo = 1; eLocked = 0; mMeas = 0;
      mBuf.delete(); mHighBuf.delete();
    end else begin
      mBuf.push_back(s); mHighBuf.push_back(int'(newLevel));
    end
    mLevel = newLevel;
  endtask

  task automatic compareAll(input string tag);
    checkOutput({tag, ".result_valid"}, int'(wif.result_valid), int'(eRv));
    checkOutput({tag, ".timeout"},      int'(wif.timeout),      int'(eTo));
    checkOutput({tag, ".locked"},       int'(wif.locked),       int'(eLocked));
    checkOutput({tag, ".period"},       int'(wif.period),       ePeriod);
    checkOutput({tag, ".high_time"},    int'(wif.high_time),    eHigh);
    checkOutput({tag, ".peak_max"},     int'(wif.peak_max),     eMax);
    checkOutput({tag, ".peak_min"},     int'(wif.peak_min),     eMin);
  endtask

  // One clock of stimulus; caller is positioned just after a posedge.
  task automatic applyStimulus(input int s, input bit v, input string tag);
    wif.sample_in    = 16'(s);
    wif.sample_valid = v;
    modelStep(s, v, int'(wif.hysteresis));
    @(posedge clk);
    #1;
    if (wif.result_valid) pulseCount++;
    compareAll(tag);
  endtask

  // Sends one valid sample, preceded by random invalid cycles carrying junk.
  task automatic sendSample(input int s, input int skipPct, input string tag);
    while ($urandom_range(99) < skipPct) begin
      applyStimulus(int'($urandom_range(65535)) - 32768, 1'b0, tag);
    end
    applyStimulus(s, 1'b1, tag);
  endtask

  task automatic sendChatter(input int maxLen, input string tag);
    int n;
    n = (maxLen > 0) ? int'($urandom_range(maxLen)) : 0;
    for (int i = 0; i < n; i++) begin
      sendSample(int'($urandom_range(100)) - 50, 0, tag);
    end
  endtask

  task automatic squareWave(input int hi, input int lo, input int nHi, input int nLo,
                            input int reps, input int skipPct, input int chat,
                            input string tag);
    for (int r = 0; r < reps; r++) begin
      for (int i = 0; i < nHi; i++) sendSample(hi, skipPct, tag);
      sendChatter(chat, tag);
      for (int i = 0; i < nLo; i++) sendSample(lo, skipPct, tag);
      sendChatter(chat, tag);
    end
  endtask

  // One-cycle asynchronous reset; outputs checked while reset is held.
  task automatic pulseReset(input string tag);
    rst = 1'b1;
    wif.sample_valid = 1'b0;
    #2;
    modelReset();
    compareAll(tag);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    wif.sample_in    = '0;
    wif.sample_valid = 1'b0;
    wif.hysteresis   = 15'd100;
    modelReset();
    #12;
    compareAll("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Clean square wave: 3 high, 7 low.
    squareWave(1000, -1000, 3, 7, 6, 0, 0, "square");
    checkOutput("square.direct_period", int'(wif.period), 10);
    checkOutput("square.direct_high",   int'(wif.high_time), 3);
    checkOutput("square.direct_max",    int'(wif.peak_max), 1000);
    checkOutput("square.direct_min",    int'(wif.peak_min), -1000);

    // Same with gaps in sample_valid; pulses = rises - 1 after a fresh reset.
    pulseReset("gapReset");
    pulseCount = 0;
    squareWave(1000, -1000, 3, 7, 8, 50, 0, "gaps");
    sendSample(1000, 50, "gaps");
    checkOutput("gaps.pulse_count", pulseCount, 8);
    checkOutput("gaps.direct_period", int'(wif.period), 10);

    // Chatter around zero at each crossing.
    squareWave(1000, -1000, 3, 7, 8, 20, 3, "chatter");

    // Lock then hold zero until timeout, results held.
    squareWave(1000, -1000, 3, 7, 3, 0, 0, "lockTo");
    sendSample(1000, 0, "lockTo");
    for (int i = 0; i < 70; i++) sendSample(0, 0, "zeros");
    checkOutput("zeros.direct_locked", int'(wif.locked), 0);
    checkOutput("zeros.direct_period", int'(wif.period), 10);

    // Dead input in acquisition also times out.
    for (int i = 0; i < 70; i++) sendSample(-5, 10, "dead");

    // Reset midway through a locked period.
    squareWave(1000, -1000, 3, 7, 3, 0, 0, "preRst");
    sendSample(1000, 0, "preRst");
    sendSample(-1000, 0, "preRst");
    pulseReset("midReset");
    squareWave(1000, -1000, 3, 7, 3, 0, 0, "postRst");

    // H=0: zero holds the level; full-scale signed peaks.
    wif.hysteresis = 15'd0;
    for (int r = 0; r < 4; r++) begin
      sendSample(1, 0, "hzero");  sendSample(0, 0, "hzero");
      sendSample(-1, 0, "hzero"); sendSample(0, 0, "hzero");
    end
    squareWave(32767, -32768, 4, 4, 4, 0, 0, "fullScale");
    checkOutput("fullScale.direct_max", int'(wif.peak_max), 32767);
    checkOutput("fullScale.direct_min", int'(wif.peak_min), -32768);

    // Random samples with live-changing hysteresis.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(31) == 0) wif.hysteresis = 15'($urandom_range(600));
      sendSample(int'($urandom_range(2400)) - 1200, 30, "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

  // Hard bound on simulated time.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
